// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder datapath: FSM encoding and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell stepped LSB-first with a registered carry,
// operands and result exchanged over valid/ready handshakes.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and data is sampled only at that edge.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;
    logic             xfer;

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign sum       = sum_q;
    assign carry_out = cout_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        if (xfer) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = c_in;
            cnt_d   = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    // Shift form rather than a slice so WIDTH=1 stays legal.
                    sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry_d  = fa_c;
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        // The visible result is only updated here so it holds across later operations.
                        sum_d   = sum_sh_d;
                        cout_d  = fa_c;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance for the main scenarios, WIDTH=1 instance for the truth-table sweep.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, c_in, out_valid, out_ready, carry_out, busy;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, c_in1, out_valid1, out_ready1, carry_out1, busy1;
    logic [0:0] a1, b1, sum1;

    int         n_checks;
    int         n_pass;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    serial_adder #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry_out (carry_out1),
        .busy      (busy1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drivers (all timing relative to the sample point 1ns after a rising edge)
    task automatic send_op(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i);
        int n;
        n = 0;
        a = a_i;
        b = b_i;
        c_in = c_i;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                          input logic c_i, input logic [8:0] exp);
        int lat, busy_n;
        send_op(a_i, b_i, c_i);
        wait_result(lat, busy_n);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_result"}, 32'({carry_out, sum}), 32'(exp));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        consume();
        check({tag, "_idle_after"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int t, got, lat;
        int t_res[2];
        logic [8:0] exp_v;

        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'({carry_out, sum}), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic", 8'h5A, 8'h3C, 1'b0, 9'h096);
        run_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Backpressure: result must sit still while out_ready is low
        send_op(8'h12, 8'h34, 1'b0);
        wait_result(lat, t);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_result", 32'({carry_out, sum}), 32'h046);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        consume();
        check("bp_after_hs", 32'({out_valid, in_ready, busy}), 32'b010);
        check("bp_result_kept", 32'({carry_out, sum}), 32'h046);
        @(posedge clk); #1;
        check("bp_single_hs", 32'(out_valid), 32'd0);

        // Back-to-back with out_ready held high
        exp_q.push_back(9'h003);
        exp_q.push_back(9'h031);
        out_ready = 1'b1;
        a = 8'h01; b = 8'h02; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20; c_in = 1'b1;
        t = 0;
        got = 0;
        while (got < 2 && t < 60) begin
            if (out_valid) begin
                check("b2b_result", 32'({carry_out, sum}), 32'(exp_q.pop_front()));
                t_res[got] = t;
                got++;
                @(posedge clk); #1;
                t++;
                if (got == 1) begin
                    in_valid = 1'b0;
                    check("b2b_accept_same_edge", 32'(busy), 32'd1);
                end
            end else begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("b2b_count", 32'(got), 32'd2);
        if (got == 2) check("b2b_spacing", 32'(t_res[1] - t_res[0]), 32'd9);
        out_ready = 1'b0;
        check("b2b_idle_after", 32'({out_valid, busy, in_ready}), 32'b001);
        check("b2b_result_kept", 32'({carry_out, sum}), 32'h031);

        // Reset 3 cycles into an operation
        send_op(8'hAA, 8'h55, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", 32'({carry_out, sum}), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'({out_valid, busy}), 32'd0);
        run_op("post_rst", 8'h0F, 8'h01, 1'b0, 9'h010);

        // WIDTH=1 truth-table sweep
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2];
            b1 = v[1];
            c_in1 = v[0];
            exp_v = 9'($countones(v));
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w1_latency", 32'(lat), 32'd1);
            check("w1_result", 32'({carry_out1, sum1}), 32'(exp_v));
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
